// File: rtl/snn_pkg.sv
// ==== snn_pkg : shared fp32 constants and sweep FSM encoding for the SNN core (rev 1.0) ====
`default_nettype none

package snn_pkg;

  localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_DECAY = 32'h3F66_6666;
  localparam logic [31:0] DEFAULT_VTH   = 32'h4215_AE14;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 3'd0;
  localparam seq_state_t ST_DECAY = 3'd1;
  localparam seq_state_t ST_ADD   = 3'd2;
  localparam seq_state_t ST_WB    = 3'd3;
  localparam seq_state_t ST_FIN   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/neuron_decay_sequencer_if.sv
// ==== neuron_decay_sequencer_if : sequencer <-> LIF potential adder bus (rev 1.0) ====
`default_nettype none

interface neuron_decay_sequencer_if;

  logic        adder_clear;
  logic [31:0] adder_input_weight;
  logic [31:0] adder_decayed_potential;
  logic [31:0] adder_final_potential;
  logic        adder_spike;

  modport master (
    output adder_clear,
    output adder_input_weight,
    output adder_decayed_potential,
    input  adder_final_potential,
    input  adder_spike
  );

  modport slave (
    input  adder_clear,
    input  adder_input_weight,
    input  adder_decayed_potential,
    output adder_final_potential,
    output adder_spike
  );

endinterface

`default_nettype wire

// File: rtl/Multiplication.sv
// ==== Multiplication : combinational fp32 multiplier, round-to-nearest-even, subnormals flushed (rev 1.0) ====
`default_nettype none

module Multiplication (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        Exception,
  output logic [31:0] result
);

  logic        sign;
  logic        a_zero;
  logic        b_zero;
  logic        in_special;
  logic [47:0] prod;
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] rounded;
  logic [10:0] exp_res;
  logic [10:0] exp_fin;
  logic        overflow;

  always_comb begin
    sign       = a_operand[31] ^ b_operand[31];
    a_zero     = (a_operand[30:23] == 8'd0);
    b_zero     = (b_operand[30:23] == 8'd0);
    in_special = (&a_operand[30:23]) | (&b_operand[30:23]);
    prod       = {1'b1, a_operand[22:0]} * {1'b1, b_operand[22:0]};

    // Biased exponent in 11-bit two's complement; bit 10 set means underflow.
    exp_res = {3'b000, a_operand[30:23]} + {3'b000, b_operand[30:23]}
            + {10'd0, prod[47]} - 11'd127;

    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    round_up = guard & (sticky | frac[0]);
    rounded  = {1'b0, frac} + {23'd0, round_up};
    exp_fin  = exp_res + {10'd0, rounded[23]};
    overflow = !exp_fin[10] && (exp_fin >= 11'd255);

    Exception = in_special | (overflow & !a_zero & !b_zero);

    if (in_special) begin
      result = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero || exp_fin[10] || (exp_fin == 11'd0)) begin
      result = {sign, 31'd0};
    end else if (overflow) begin
      result = {sign, 8'hFF, 23'd0};
    end else begin
      result = {sign, exp_fin[7:0], rounded[22:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_decay_sequencer.sv
// ==== neuron_decay_sequencer : per-timestep leak-and-integrate sweep over all neurons (rev 1.0) ====
`default_nettype none

module neuron_decay_sequencer
  import snn_pkg::*;
#(
  parameter int          NUM_NEURONS  = 8,
  parameter int          IDX_W        = 3,
  parameter logic [31:0] DECAY_FACTOR = DEFAULT_DECAY
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     timestep_start,
  input  logic                     weight_wr_en,
  input  logic [IDX_W-1:0]         weight_wr_idx,
  input  logic [31:0]              weight_wr_data,
  output logic                     weight_wr_ready,
  neuron_decay_sequencer_if.master adder,
  output logic                     spike_valid,
  output logic [IDX_W-1:0]         spike_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     mul_error
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [IDX_W-1:0] idx;
  logic             last_idx;
  logic [31:0]      pot_mem    [NUM_NEURONS];
  logic [31:0]      weight_mem [NUM_NEURONS];
  logic [31:0]      mul_result;
  logic             mul_exception;

  assign last_idx = (idx == IDX_W'(NUM_NEURONS - 1));

  Multiplication u_decay_mul (
    .a_operand (pot_mem[idx]),
    .b_operand (DECAY_FACTOR),
    .Exception (mul_exception),
    .result    (mul_result)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (timestep_start) state_nxt = ST_DECAY;
      ST_DECAY: state_nxt = ST_ADD;
      ST_ADD:   state_nxt = ST_WB;
      ST_WB:    state_nxt = last_idx ? ST_FIN : ST_DECAY;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The adder stays cleared only while idle so its result is stable through ADD and WB.
  always_comb begin
    busy              = (state != ST_IDLE);
    weight_wr_ready   = (state == ST_IDLE);
    adder.adder_clear = (state == ST_IDLE);
    spike_valid       = (state == ST_WB) && adder.adder_spike;
    spike_idx         = idx;
    done              = (state == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      idx                           <= '0;
      mul_error                     <= 1'b0;
      adder.adder_input_weight      <= FP_ZERO;
      adder.adder_decayed_potential <= FP_ZERO;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_mem[i]    <= FP_ZERO;
        weight_mem[i] <= FP_ZERO;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (timestep_start) idx <= '0;
        end
        ST_DECAY: begin
          adder.adder_input_weight      <= weight_mem[idx];
          adder.adder_decayed_potential <= mul_exception ? FP_ZERO : mul_result;
          if (mul_exception) mul_error <= 1'b1;
        end
        ST_WB: begin
          pot_mem[idx]    <= adder.adder_final_potential;
          weight_mem[idx] <= FP_ZERO;
          if (!last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase

      // Writes in the start cycle land before DECAY of any neuron reads them.
      if (weight_wr_en && (state == ST_IDLE)) begin
        weight_mem[weight_wr_idx] <= weight_wr_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_decay_sequencer.sv
// ==== tb_neuron_decay_sequencer : scoreboard bench with a behavioural fp32 LIF adder (rev 1.0) ====
`default_nettype none

module tb_neuron_decay_sequencer;
  import snn_pkg::*;

  localparam int  N        = 8;
  localparam real VTH_REAL = 37.42;

  logic        clk;
  logic        clear;
  logic        timestep_start;
  logic        weight_wr_en;
  logic [2:0]  weight_wr_idx;
  logic [31:0] weight_wr_data;
  wire         weight_wr_ready;
  wire         spike_valid;
  wire  [2:0]  spike_idx;
  wire         busy;
  wire         done;
  wire         mul_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_pot [N];
  logic [31:0] model_w   [N];
  logic        model_err;
  logic [31:0] exp_dec_q[$];
  logic [31:0] exp_w_q[$];
  int          exp_spk_idx_q[$];
  int          exp_spk_cyc_q[$];
  int          got_spk_cyc_q[$];

  neuron_decay_sequencer_if adder_bus ();

  neuron_decay_sequencer #(
    .NUM_NEURONS  (N),
    .IDX_W        (3),
    .DECAY_FACTOR (DEFAULT_DECAY)
  ) dut (
    .clk             (clk),
    .clear           (clear),
    .timestep_start  (timestep_start),
    .weight_wr_en    (weight_wr_en),
    .weight_wr_idx   (weight_wr_idx),
    .weight_wr_data  (weight_wr_data),
    .weight_wr_ready (weight_wr_ready),
    .adder           (adder_bus),
    .spike_valid     (spike_valid),
    .spike_idx       (spike_idx),
    .busy            (busy),
    .done            (done),
    .mul_error       (mul_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real fp_to_real(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0) return {d[63], 31'h0};
    m = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) e = e + 1;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic int ulp_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? int'(a - b) : int'(b - a);
  endfunction

  // External LIF adder: subtractive reset at threshold; infinite weights pass straight through.
  function automatic logic [32:0] adder_fn(input logic [31:0] dec, input logic [31:0] w);
    real s;
    if (&w[30:23]) return {1'b0, w};
    s = fp_to_real(dec) + fp_to_real(w);
    if (s >= VTH_REAL) return {1'b1, real_to_fp(s - VTH_REAL)};
    return {1'b0, real_to_fp(s)};
  endfunction

  logic [32:0] adder_out;
  assign adder_out = adder_bus.adder_clear ? 33'h0 :
                     adder_fn(adder_bus.adder_decayed_potential, adder_bus.adder_input_weight);
  assign adder_bus.adder_spike           = adder_out[32];
  assign adder_bus.adder_final_potential = adder_out[31:0];

  task automatic predict_sweep();
    logic [31:0] dec;
    logic [32:0] ao;
    for (int k = 0; k < N; k++) begin
      if (&model_pot[k][30:23]) begin
        dec       = 32'h0;
        model_err = 1'b1;
      end else begin
        dec = real_to_fp(fp_to_real(model_pot[k]) * fp_to_real(DEFAULT_DECAY));
      end
      exp_dec_q.push_back(dec);
      exp_w_q.push_back(model_w[k]);
      ao = adder_fn(dec, model_w[k]);
      if (ao[32]) begin
        exp_spk_idx_q.push_back(k);
        exp_spk_cyc_q.push_back(3 * k + 3);
      end
      model_pot[k] = ao[31:0];
      model_w[k]   = 32'h0;
    end
  endtask

  task automatic write_weight(input logic [2:0] i, input logic [31:0] v);
    @(negedge clk);
    weight_wr_en   = 1'b1;
    weight_wr_idx  = i;
    weight_wr_data = v;
    @(negedge clk);
    weight_wr_en = 1'b0;
    model_w[i]   = v;
  endtask

  // One full sweep scored against the model; optional write alongside the start pulse and
  // an optional write+start poke while busy (poke_cyc = 0 disables it).
  task automatic run_sweep(input logic wr_with_start, input logic [2:0] wr_idx,
                           input logic [31:0] wr_data, input int poke_cyc);
    int          done_cnt;
    int          done_cyc;
    int          ei;
    int          ec;
    logic [31:0] e32;
    done_cnt = 0;
    done_cyc = -1;
    if (wr_with_start) model_w[wr_idx] = wr_data;
    predict_sweep();
    got_spk_cyc_q.delete();
    @(negedge clk);
    timestep_start = 1'b1;
    weight_wr_en   = wr_with_start;
    weight_wr_idx  = wr_idx;
    weight_wr_data = wr_data;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      timestep_start = (cyc == poke_cyc);
      weight_wr_en   = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        weight_wr_idx  = 3'd5;
        weight_wr_data = 32'h4248_0000;
        n_checks++;
        if (busy !== 1'b1 || weight_wr_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ready: got busy=%b ready=%b, required busy=1 ready=0", busy, weight_wr_ready);
        end
      end
      if (spike_valid === 1'b1) begin
        got_spk_cyc_q.push_back(cyc);
        n_checks++;
        if (exp_spk_idx_q.size() == 0) begin
          n_fail++;
          $display("FAIL spike_unexpected: got idx %0d at cycle %0d, required no spike", spike_idx, cyc);
        end else begin
          ei = exp_spk_idx_q.pop_front();
          ec = exp_spk_cyc_q.pop_front();
          if (spike_idx !== 3'(ei) || cyc != ec) begin
            n_fail++;
            $display("FAIL spike_event: got idx %0d cycle %0d, required idx %0d cycle %0d", spike_idx, cyc, ei, ec);
          end
        end
      end
      if ((cyc % 3) == 2 && cyc < 3 * N) begin
        e32 = exp_dec_q.pop_front();
        n_checks++;
        if (adder_bus.adder_decayed_potential !== e32 || adder_bus.adder_clear !== 1'b0) begin
          n_fail++;
          $display("FAIL decayed_potential: cycle %0d got %h clr=%b, required %h clr=0", cyc, adder_bus.adder_decayed_potential, adder_bus.adder_clear, e32);
        end
        e32 = exp_w_q.pop_front();
        n_checks++;
        if (adder_bus.adder_input_weight !== e32) begin
          n_fail++;
          $display("FAIL input_weight: cycle %0d got %h, required %h", cyc, adder_bus.adder_input_weight, e32);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
    end
    timestep_start = 1'b0;
    weight_wr_en   = 1'b0;
    n_checks++;
    if (done_cnt != 1 || done_cyc != 3 * N + 1) begin
      n_fail++;
      $display("FAIL done_timing: got %0d pulses first at cycle %0d, required 1 pulse at cycle %0d", done_cnt, done_cyc, 3 * N + 1);
    end
    n_checks++;
    if (exp_spk_idx_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end: got %0d missing spikes busy=%b, required 0 missing busy=0", exp_spk_idx_q.size(), busy);
    end
    exp_spk_idx_q.delete();
    exp_spk_cyc_q.delete();
    n_checks++;
    if (mul_error !== model_err) begin
      n_fail++;
      $display("FAIL mul_error: got %b, required %b", mul_error, model_err);
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dut.pot_mem[k] !== model_pot[k] || dut.weight_mem[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL mem[%0d]: got pot %h weight %h, required pot %h weight 0", k, dut.pot_mem[k], dut.weight_mem[k], model_pot[k]);
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || spike_valid !== 1'b0 || mul_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b spk=%b err=%b, required all 0", busy, done, spike_valid, mul_error);
    end
    n_checks++;
    if (weight_wr_ready !== 1'b1 || adder_bus.adder_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b adder_clear=%b, required 1 1", weight_wr_ready, adder_bus.adder_clear);
    end
    n_checks++;
    if (adder_bus.adder_decayed_potential !== 32'h0 || adder_bus.adder_input_weight !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_adder_bus: got dec %h w %h, required 0 0", adder_bus.adder_decayed_potential, adder_bus.adder_input_weight);
    end
    clear = 1'b0;
  endtask

  task automatic test_empty_sweep();
    run_sweep(1'b0, 3'd0, 32'h0, 0);
  endtask

  task automatic test_single_spike();
    write_weight(3'd3, 32'h4248_0000);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
    n_checks++;
    if (ulp_diff(dut.pot_mem[3], 32'h4149_47AE) > 1) begin
      n_fail++;
      $display("FAIL pot3_after_spike: got %h, required 414947ae +/-1 ulp", dut.pot_mem[3]);
    end
  endtask

  task automatic test_decay_only();
    logic [31:0] ref_dec;
    ref_dec = real_to_fp(11.322);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
    n_checks++;
    if (ulp_diff(dut.pot_mem[3], ref_dec) > 1) begin
      n_fail++;
      $display("FAIL pot3_decayed: got %h, required %h +/-1 ulp", dut.pot_mem[3], ref_dec);
    end
  endtask

  task automatic test_two_spikes();
    write_weight(3'd0, 32'h4248_0000);
    run_sweep(1'b1, 3'd7, 32'h4248_0000, 0);
    n_checks++;
    if (got_spk_cyc_q.size() != 2 || (got_spk_cyc_q[1] - got_spk_cyc_q[0]) != 21) begin
      n_fail++;
      $display("FAIL spike_gap: got %0d spikes, required 2 spikes 21 cycles apart", got_spk_cyc_q.size());
    end
  endtask

  task automatic test_negative();
    write_weight(3'd1, 32'hC120_0000);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
    n_checks++;
    if (dut.pot_mem[1][31] !== 1'b1) begin
      n_fail++;
      $display("FAIL negative_pot: got %h, required negative value", dut.pot_mem[1]);
    end
  endtask

  task automatic test_busy_ignored();
    run_sweep(1'b0, 3'd0, 32'h0, 10);
  endtask

  task automatic test_mul_error();
    write_weight(3'd2, 32'h7F80_0000);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
    run_sweep(1'b0, 3'd0, 32'h0, 0);
  endtask

  task automatic test_clear_mid_sweep();
    int done_cnt;
    int bad_mem;
    done_cnt = 0;
    bad_mem  = 0;
    write_weight(3'd1, 32'h4248_0000);
    @(negedge clk);
    timestep_start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      timestep_start = 1'b0;
    end
    n_checks++;
    if (adder_bus.adder_clear !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_state_before_clear: got adder_clear=%b busy=%b, required 0 1", adder_bus.adder_clear, busy);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || adder_bus.adder_clear !== 1'b1 || mul_error !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state: got busy=%b done=%b adder_clear=%b err=%b, required 0 0 1 0", busy, done, adder_bus.adder_clear, mul_error);
    end
    for (int k = 0; k < N; k++) begin
      if (dut.pot_mem[k] !== 32'h0 || dut.weight_mem[k] !== 32'h0) bad_mem++;
    end
    n_checks++;
    if (bad_mem != 0) begin
      n_fail++;
      $display("FAIL clear_memories: got %0d nonzero entries, required 0", bad_mem);
    end
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_done: got %0d done pulses busy=%b, required 0 0", done_cnt, busy);
    end
    for (int k = 0; k < N; k++) begin
      model_pot[k] = 32'h0;
      model_w[k]   = 32'h0;
    end
    model_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear          = 1'b1;
    timestep_start = 1'b0;
    weight_wr_en   = 1'b0;
    weight_wr_idx  = 3'd0;
    weight_wr_data = 32'h0;
    model_err      = 1'b0;
    for (int k = 0; k < N; k++) begin
      model_pot[k] = 32'h0;
      model_w[k]   = 32'h0;
    end
    test_reset();
    test_empty_sweep();
    test_single_spike();
    test_decay_only();
    test_two_spikes();
    test_negative();
    test_busy_ignored();
    test_mul_error();
    test_clear_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
